// File: rtl/stdout_uart_tx.sv
// stdout console path: byte FIFO feeding an 8N1 serializer.
// Stores from the memory stage are queued and shifted out on tx.
module stdout_uart_tx #(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             busy,
  output logic             tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [7:0]    mem [DEPTH];
  logic [BW-1:0] baud;
  logic [BW-1:0] baud_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          tx_n;
  logic          pop;
  logic          push;
  logic          last;

  assign full  = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign busy  = state != IDLE;
  assign last  = baud == BW'(CLKS_PER_BIT - 1);
  // a same-edge pop frees the slot, so a push into a full FIFO still lands
  assign push  = wr_en && (!full || pop);

  // FIFO storage: written only on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and sticky drop flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !push) begin
        overflow <= 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // serializer state register; tx is registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

  // next state, FIFO pop and next tx level
  always_comb begin
    state_n = state;
    baud_n  = baud + BW'(1);
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
        end
      end
      START: begin
        if (last) begin
          baud_n  = '0;
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (last) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) begin
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (last) begin
          baud_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    tx_n = 1'b1;
    if (state_n == START) begin
      tx_n = 1'b0;
    end else if (state_n == DATA) begin
      tx_n = shift_n[0];
    end
  end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Bench for stdout_uart_tx: queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_stdout_uart_tx;

  localparam int DEPTH = 8;
  localparam int CPB   = 16;
  localparam int CNT_W = 4;
  localparam int FLEN  = 10 * CPB;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             busy;
  logic             tx;

  int total = 0;
  int bad   = 0;

  stdout_uart_tx #(
    .DEPTH(DEPTH),
    .CLKS_PER_BIT(CPB),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .busy(busy),
    .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: queue of pending bytes plus position inside the frame on the wire
  byte unsigned q[$];
  bit           m_ok  = 0;
  bit           m_act = 0;
  int           m_pos = 0;
  byte unsigned m_byte = 0;
  bit           m_ovf = 0;

  always @(posedge clk) begin
    bit pop;
    int sz;
    pop = 0;
    sz  = q.size();
    if (!rst_n) begin
      q.delete();
      m_act = 0;
      m_pos = 0;
      m_ovf = 0;
      m_ok  = 1;
    end else begin
      if (m_act && m_pos < FLEN - 1) begin
        m_pos++;
      end else if (sz > 0) begin
        pop    = 1;
        m_byte = q.pop_front();
        m_act  = 1;
        m_pos  = 0;
      end else begin
        m_act = 0;
      end
      if (wr_en) begin
        if (sz < DEPTH || pop) q.push_back(wr_data);
        else m_ovf = 1;
      end
    end
  end

  function automatic int exp_tx();
    int k;
    if (!m_act) return 1;
    k = m_pos / CPB;
    if (k == 0) return 0;
    if (k == 9) return 1;
    return int'(m_byte[k-1]);
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_tx", tx, exp_tx());
      chk("m_busy", busy, int'(m_act));
      chk("m_count", count, q.size());
      chk("m_empty", empty, int'(q.size() == 0));
      chk("m_full", full, int'(q.size() == DEPTH));
      chk("m_ovf", overflow, int'(m_ovf));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    wr_en = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1;
      wr_data = 8'(base + i);
      @(negedge clk);
    end
    wr_en = 0;
  endtask

  logic [9:0] f41;
  int         pr [6];

  initial begin
    rst_n   = 1;
    wr_en   = 0;
    wr_data = 0;
    repeat (2) @(negedge clk);

    rst_n   = 0;
    wr_en   = 1;
    wr_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_empty", empty, 1);
      chk("rst_cnt", count, 0);
      chk("rst_ovf", overflow, 0);
    end
    rst_n = 1;
    wr_en = 0;
    repeat (20) @(negedge clk);
    chk("rel_busy", busy, 0);
    chk("rel_tx", tx, 1);

    f41     = 10'b1_0100_0001_0;
    wr_en   = 1;
    wr_data = 8'h41;
    @(negedge clk);
    wr_en = 0;
    chk("b41_empty_n", empty, 0);
    @(negedge clk);
    chk("b41_empty_n1", empty, 1);
    chk("b41_busy", busy, 1);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("b41_bit%0d", k), tx, int'(f41[k]));
      if (k < 9) repeat (16) @(negedge clk);
    end
    repeat (7) @(negedge clk);
    chk("b41_busy160", busy, 1);
    @(negedge clk);
    chk("b41_busy161", busy, 0);

    do_reset();
    push_n(9, 0);
    chk("fill_cnt", count, 8);
    chk("fill_ovf", overflow, 0);
    chk("fill_full", full, 1);
    wr_en   = 1;
    wr_data = 8'h09;
    @(negedge clk);
    wr_en = 0;
    chk("fill10_ovf", overflow, 1);
    chk("fill10_cnt", count, 8);
    repeat (9 * FLEN + 20) @(negedge clk);
    chk("fill_drain_empty", empty, 1);
    chk("fill_drain_busy", busy, 0);
    chk("fill_drain_ovf", overflow, 1);

    do_reset();
    push_n(9, 8'h30);
    repeat (152) @(negedge clk);
    chk("fp_cnt_pre", count, 8);
    chk("fp_busy_pre", busy, 1);
    wr_en   = 1;
    wr_data = 8'h5A;
    @(negedge clk);
    chk("fp_cnt", count, 8);
    chk("fp_ovf", overflow, 0);
    chk("fp_full", full, 1);
    wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 0;
    chk("ovf_set", overflow, 1);
    chk("ovf_cnt", count, 8);
    repeat (9 * FLEN + 20) @(negedge clk);
    chk("ovf_drain_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);
    do_reset();
    @(negedge clk);
    chk("ovf_clr", overflow, 0);

    do_reset();
    push_n(3, 8'h08);
    repeat (67) @(negedge clk);
    chk("mid_bit3", tx, 1);
    chk("mid_busy", busy, 1);
    rst_n = 0;
    @(negedge clk);
    chk("mid_tx", tx, 1);
    chk("mid_busy_r", busy, 0);
    chk("mid_cnt", count, 0);
    rst_n = 1;
    repeat (200) @(negedge clk);
    chk("mid_after_busy", busy, 0);
    chk("mid_after_tx", tx, 1);

    pr = '{3, 20, 60, 95, 10, 100};
    for (int b = 0; b < 6; b++) begin
      for (int c = 0; c < 700; c++) begin
        wr_en   = ($urandom_range(0, 99) < pr[b]);
        wr_data = 8'($urandom);
        rst_n   = ($urandom_range(0, 1999) != 0);
        @(negedge clk);
      end
    end
    wr_en = 0;
    rst_n = 1;
    repeat (DEPTH * FLEN + 200) @(negedge clk);
    chk("end_empty", empty, 1);
    chk("end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
